// File: rtl/field_ram_pp_if.sv
// Port bundle between the Game of Life field store and its step engine / display scanner.
interface field_ram_pp_if #(
    parameter int FIELD_W   = 64,
    parameter int FIELD_H   = 48,
    parameter int GEN_CNT_W = 16
);
    localparam int X_ADR_SIZE     = $clog2(FIELD_W);
    localparam int Y_ADR_SIZE     = $clog2(FIELD_H);
    localparam int NEIGHBOURS_CNT = 8;

    logic [X_ADR_SIZE-1:0]     i_cell_x_adr_prw1;
    logic [Y_ADR_SIZE-1:0]     i_cell_y_adr_prw1;
    logic [X_ADR_SIZE-1:0]     i_cell_x_adr_pr2;
    logic [Y_ADR_SIZE-1:0]     i_cell_y_adr_pr2;
    logic                      i_w_en_p1;
    logic                      i_new_cell_state_p1;
    logic                      i_swap_req;
    logic                      i_clear_req;
    logic                      o_cell_state_pr1;
    logic [NEIGHBOURS_CNT-1:0] o_nbrs_pr1;
    logic                      o_cell_state_pr2;
    logic                      o_busy;
    logic                      o_bank_sel;
    logic [GEN_CNT_W-1:0]      o_gen_cnt;

    modport master (
        output i_cell_x_adr_prw1, i_cell_y_adr_prw1, i_cell_x_adr_pr2, i_cell_y_adr_pr2,
        output i_w_en_p1, i_new_cell_state_p1, i_swap_req, i_clear_req,
        input  o_cell_state_pr1, o_nbrs_pr1, o_cell_state_pr2, o_busy, o_bank_sel, o_gen_cnt
    );

    modport slave (
        input  i_cell_x_adr_prw1, i_cell_y_adr_prw1, i_cell_x_adr_pr2, i_cell_y_adr_pr2,
        input  i_w_en_p1, i_new_cell_state_p1, i_swap_req, i_clear_req,
        output o_cell_state_pr1, o_nbrs_pr1, o_cell_state_pr2, o_busy, o_bank_sel, o_gen_cnt
    );
endinterface

// File: rtl/field_ram_pp.sv
// Double-buffered Game of Life field: reads (cell + 8 neighbours, display) from the current
// bank, writes to the next bank, atomic swap between generations, sweep-clear of both banks.
module field_ram_pp #(
    parameter int FIELD_W   = 64,
    parameter int FIELD_H   = 48,
    parameter int WRAP      = 0,
    parameter int GEN_CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    field_ram_pp_if.slave bus
);
    localparam int X_ADR_SIZE     = $clog2(FIELD_W);
    localparam int Y_ADR_SIZE     = $clog2(FIELD_H);
    localparam int NEIGHBOURS_CNT = 8;
    localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                    state;
    logic [X_ADR_SIZE-1:0]     clr_x;
    logic [Y_ADR_SIZE-1:0]     clr_y;
    logic                      bank_sel;
    logic [GEN_CNT_W-1:0]      gen_cnt;
    logic                      busy;
    logic [FIELD_W-1:0]        mem [2][FIELD_H];

    logic [X_ADR_SIZE-1:0]     x1, x2, xm, xp;
    logic [Y_ADR_SIZE-1:0]     y1, y2, ym, yp;
    logic                      in1, in2, xm_ok, xp_ok, ym_ok, yp_ok;
    logic                      cell1_p0, cell2_p0;
    logic [NEIGHBOURS_CNT-1:0] nbrs_p0;

    function automatic logic in_field(logic [X_ADR_SIZE-1:0] x, logic [Y_ADR_SIZE-1:0] y);
        return (x <= X_LAST) && (y <= Y_LAST);
    endfunction

    // Stage p0: neighbour address generation and current-bank lookup
    always_comb begin
        x1    = bus.i_cell_x_adr_prw1;
        y1    = bus.i_cell_y_adr_prw1;
        x2    = bus.i_cell_x_adr_pr2;
        y2    = bus.i_cell_y_adr_pr2;
        in1   = in_field(x1, y1);
        in2   = in_field(x2, y2);
        xm    = (x1 == '0)     ? X_LAST : x1 - X_ADR_SIZE'(1);
        xp    = (x1 == X_LAST) ? '0     : x1 + X_ADR_SIZE'(1);
        ym    = (y1 == '0)     ? Y_LAST : y1 - Y_ADR_SIZE'(1);
        yp    = (y1 == Y_LAST) ? '0     : y1 + Y_ADR_SIZE'(1);
        xm_ok = (WRAP != 0) || (x1 != '0);
        xp_ok = (WRAP != 0) || (x1 != X_LAST);
        ym_ok = (WRAP != 0) || (y1 != '0);
        yp_ok = (WRAP != 0) || (y1 != Y_LAST);
        cell1_p0 = 1'b0;
        nbrs_p0  = '0;
        if (in1) begin
            cell1_p0   = mem[bank_sel][y1][x1];
            nbrs_p0[0] = xm_ok && ym_ok && mem[bank_sel][ym][xm];
            nbrs_p0[1] = ym_ok && mem[bank_sel][ym][x1];
            nbrs_p0[2] = xp_ok && ym_ok && mem[bank_sel][ym][xp];
            nbrs_p0[3] = xm_ok && mem[bank_sel][y1][xm];
            nbrs_p0[4] = xp_ok && mem[bank_sel][y1][xp];
            nbrs_p0[5] = xm_ok && yp_ok && mem[bank_sel][yp][xm];
            nbrs_p0[6] = yp_ok && mem[bank_sel][yp][x1];
            nbrs_p0[7] = xp_ok && yp_ok && mem[bank_sel][yp][xp];
        end
        cell2_p0 = in2 && mem[bank_sel][y2][x2];
    end

    // Stage p1: registered read ports, bank/generation control and clear sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_CLEAR;
            busy                 <= 1'b1;
            clr_x                <= '0;
            clr_y                <= '0;
            bank_sel             <= 1'b0;
            gen_cnt              <= '0;
            bus.o_cell_state_pr1 <= 1'b0;
            bus.o_nbrs_pr1       <= '0;
            bus.o_cell_state_pr2 <= 1'b0;
        end else begin
            if (state == ST_CLEAR) begin
                bus.o_cell_state_pr1 <= 1'b0;
                bus.o_nbrs_pr1       <= '0;
                bus.o_cell_state_pr2 <= 1'b0;
            end else begin
                bus.o_cell_state_pr1 <= cell1_p0;
                bus.o_nbrs_pr1       <= nbrs_p0;
                bus.o_cell_state_pr2 <= cell2_p0;
            end
            case (state)
                ST_CLEAR: begin
                    bank_sel <= 1'b0;
                    gen_cnt  <= '0;
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        if (clr_y == Y_LAST) begin
                            clr_y <= '0;
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            clr_y <= clr_y + Y_ADR_SIZE'(1);
                        end
                    end else begin
                        clr_x <= clr_x + X_ADR_SIZE'(1);
                    end
                end
                default: begin
                    // A clear request pre-empts a swap issued in the same cycle
                    if (bus.i_clear_req) begin
                        state    <= ST_CLEAR;
                        busy     <= 1'b1;
                        clr_x    <= '0;
                        clr_y    <= '0;
                        bank_sel <= 1'b0;
                        gen_cnt  <= '0;
                    end else if (bus.i_swap_req) begin
                        bank_sel <= ~bank_sel;
                        gen_cnt  <= gen_cnt + GEN_CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Storage: sweep zeroes both banks; otherwise the step engine writes the next bank
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[0][clr_y][clr_x] <= 1'b0;
            mem[1][clr_y][clr_x] <= 1'b0;
        end else if (bus.i_w_en_p1 && in1 && !bus.i_clear_req) begin
            mem[~bank_sel][y1][x1] <= bus.i_new_cell_state_p1;
        end
    end

    assign bus.o_busy     = busy;
    assign bus.o_bank_sel = bank_sel;
    assign bus.o_gen_cnt  = gen_cnt;
endmodule

// File: tb/tb_field_ram_pp.sv
// Bench for field_ram_pp: three instances (4x3 bounded, 4x3 toroidal with 2-bit gen counter,
// 5x3 toroidal) driven in lockstep, checked against a reference model and hand-derived vectors.
module tb_field_ram_pp;
    localparam int M_C1 = 1, M_NB = 2, M_C2 = 4, M_BUSY = 8, M_SEL = 16, M_GEN = 32;

    typedef struct {
        int x1, y1, x2, y2, cx1, cy1, cx2, cy2;
        bit we, ns, swp, clr;
        int hd, hm;
        bit hc1; logic [7:0] hnb; bit hc2; bit hbusy; bit hsel; int hgen;
    } vec_t;

    typedef struct {
        int d; bit c1; logic [7:0] nb; bit c2; bit busy; bit sel; int gen;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] ax1, ay1, ax2, ay2, cx1, cy1, cx2, cy2;
    logic we, ns, swp, clr;
    int vectors = 0;
    int miscompares = 0;
    exp_t q[$];

    bit mm [3][2][3][5];
    bit mbusy [3];
    int mcnt [3], msel [3], mgen [3];

    always #5 clk = ~clk;

    field_ram_pp_if #(.FIELD_W(4), .FIELD_H(3), .GEN_CNT_W(16)) ifa ();
    field_ram_pp_if #(.FIELD_W(4), .FIELD_H(3), .GEN_CNT_W(2))  ifb ();
    field_ram_pp_if #(.FIELD_W(5), .FIELD_H(3), .GEN_CNT_W(16)) ifc ();

    field_ram_pp #(.FIELD_W(4), .FIELD_H(3), .WRAP(0), .GEN_CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    field_ram_pp #(.FIELD_W(4), .FIELD_H(3), .WRAP(1), .GEN_CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    field_ram_pp #(.FIELD_W(5), .FIELD_H(3), .WRAP(1), .GEN_CNT_W(16)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    assign ifa.i_cell_x_adr_prw1 = ax1[1:0];
    assign ifa.i_cell_y_adr_prw1 = ay1[1:0];
    assign ifa.i_cell_x_adr_pr2  = ax2[1:0];
    assign ifa.i_cell_y_adr_pr2  = ay2[1:0];
    assign ifb.i_cell_x_adr_prw1 = ax1[1:0];
    assign ifb.i_cell_y_adr_prw1 = ay1[1:0];
    assign ifb.i_cell_x_adr_pr2  = ax2[1:0];
    assign ifb.i_cell_y_adr_pr2  = ay2[1:0];
    assign ifc.i_cell_x_adr_prw1 = cx1[2:0];
    assign ifc.i_cell_y_adr_prw1 = cy1[1:0];
    assign ifc.i_cell_x_adr_pr2  = cx2[2:0];
    assign ifc.i_cell_y_adr_pr2  = cy2[1:0];
    assign ifa.i_w_en_p1 = we;  assign ifb.i_w_en_p1 = we;  assign ifc.i_w_en_p1 = we;
    assign ifa.i_new_cell_state_p1 = ns;
    assign ifb.i_new_cell_state_p1 = ns;
    assign ifc.i_new_cell_state_p1 = ns;
    assign ifa.i_swap_req = swp; assign ifb.i_swap_req = swp; assign ifc.i_swap_req = swp;
    assign ifa.i_clear_req = clr; assign ifb.i_clear_req = clr; assign ifc.i_clear_req = clr;

    function automatic int pw(int d);   return (d == 2) ? 5 : 4; endfunction
    function automatic int pxa(int d);  return (d == 2) ? 3 : 2; endfunction
    function automatic int pgw(int d);  return (d == 1) ? 2 : 16; endfunction
    function automatic bit pwrap(int d); return d != 0; endfunction

    function automatic bit rd(int d, int b, int x, int y);
        if (x < 0 || x >= pw(d) || y < 0 || y >= 3) return 1'b0;
        return mm[d][b][y][x];
    endfunction

    function automatic vec_t mk(int x1, int y1, int x2, int y2, bit w, bit n, bit s, bit c);
        vec_t v;
        v.x1 = x1; v.y1 = y1; v.x2 = x2; v.y2 = y2;
        v.cx1 = x1; v.cy1 = y1; v.cx2 = x2; v.cy2 = y2;
        v.we = w; v.ns = n; v.swp = s; v.clr = c;
        v.hd = -1; v.hm = 0; v.hc1 = 0; v.hnb = '0; v.hc2 = 0; v.hbusy = 0; v.hsel = 0; v.hgen = 0;
        return v;
    endfunction

    function automatic vec_t hck(vec_t vi, int d, int m, bit c1, logic [7:0] nb, bit c2,
                                 bit b, bit s, int g);
        vec_t v = vi;
        v.hd = d; v.hm = m; v.hc1 = c1; v.hnb = nb; v.hc2 = c2; v.hbusy = b; v.hsel = s; v.hgen = g;
        return v;
    endfunction

    task automatic model_push(int d, int x1, int y1, int x2, int y2, bit w, bit n, bit s, bit c);
        exp_t e;
        int xe1 = x1 % (1 << pxa(d)), ye1 = y1 % 4, xe2 = x2 % (1 << pxa(d)), ye2 = y2 % 4;
        bit in1 = (xe1 < pw(d)) && (ye1 < 3);
        e.d = d; e.c1 = 0; e.nb = '0; e.c2 = 0;
        if (!mbusy[d]) begin
            e.c1 = rd(d, msel[d], xe1, ye1);
            e.c2 = rd(d, msel[d], xe2, ye2);
            for (int k = 0; k < 8 && in1; k++) begin
                int dx = (k == 0 || k == 3 || k == 5) ? -1 : ((k == 1 || k == 6) ? 0 : 1);
                int dy = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
                int nx = xe1 + dx, ny = ye1 + dy;
                if (pwrap(d)) begin
                    nx = (nx + pw(d)) % pw(d);
                    ny = (ny + 3) % 3;
                end
                e.nb[k] = rd(d, msel[d], nx, ny);
            end
        end
        if (mbusy[d]) begin
            mm[d][0][mcnt[d] / pw(d)][mcnt[d] % pw(d)] = 1'b0;
            mm[d][1][mcnt[d] / pw(d)][mcnt[d] % pw(d)] = 1'b0;
            msel[d] = 0; mgen[d] = 0;
            mcnt[d]++;
            if (mcnt[d] == pw(d) * 3) mbusy[d] = 1'b0;
        end else if (c) begin
            mbusy[d] = 1'b1; mcnt[d] = 0; msel[d] = 0; mgen[d] = 0;
        end else begin
            if (w && in1) mm[d][1 - msel[d]][ye1][xe1] = n;
            if (s) begin
                msel[d] = 1 - msel[d];
                mgen[d] = (mgen[d] + 1) % (1 << pgw(d));
            end
        end
        e.busy = mbusy[d]; e.sel = msel[d][0]; e.gen = mgen[d];
        q.push_back(e);
    endtask

    task automatic get_act(int d, output bit c1, output logic [7:0] nb, output bit c2,
                           output bit b, output bit s, output int g);
        case (d)
            0: begin c1 = ifa.o_cell_state_pr1; nb = ifa.o_nbrs_pr1; c2 = ifa.o_cell_state_pr2;
                     b = ifa.o_busy; s = ifa.o_bank_sel; g = int'(ifa.o_gen_cnt); end
            1: begin c1 = ifb.o_cell_state_pr1; nb = ifb.o_nbrs_pr1; c2 = ifb.o_cell_state_pr2;
                     b = ifb.o_busy; s = ifb.o_bank_sel; g = int'(ifb.o_gen_cnt); end
            default: begin c1 = ifc.o_cell_state_pr1; nb = ifc.o_nbrs_pr1; c2 = ifc.o_cell_state_pr2;
                     b = ifc.o_busy; s = ifc.o_bank_sel; g = int'(ifc.o_gen_cnt); end
        endcase
    endtask

    task automatic cmp(exp_t e, int m, string name);
        bit c1, c2, b, s; logic [7:0] nb; int g; bit bad;
        get_act(e.d, c1, nb, c2, b, s, g);
        bad = ((m & M_C1) != 0 && c1 != e.c1) || ((m & M_NB) != 0 && nb != e.nb) ||
              ((m & M_C2) != 0 && c2 != e.c2) || ((m & M_BUSY) != 0 && b != e.busy) ||
              ((m & M_SEL) != 0 && s != e.sel) || ((m & M_GEN) != 0 && g != e.gen);
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s dut%0d @%0t: got c1=%0b nb=%h c2=%0b busy=%0b sel=%0b gen=%0d, want c1=%0b nb=%h c2=%0b busy=%0b sel=%0b gen=%0d (mask %0d)",
                     name, e.d, $time, c1, nb, c2, b, s, g, e.c1, e.nb, e.c2, e.busy, e.sel, e.gen, m);
        end
    endtask

    task automatic cmp_int(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic step(vec_t v);
        exp_t h;
        ax1 = 4'(v.x1); ay1 = 4'(v.y1); ax2 = 4'(v.x2); ay2 = 4'(v.y2);
        cx1 = 4'(v.cx1); cy1 = 4'(v.cy1); cx2 = 4'(v.cx2); cy2 = 4'(v.cy2);
        we = v.we; ns = v.ns; swp = v.swp; clr = v.clr;
        for (int d = 0; d < 3; d++) begin
            if (d < 2) model_push(d, v.x1, v.y1, v.x2, v.y2, v.we, v.ns, v.swp, v.clr);
            else       model_push(d, v.cx1, v.cy1, v.cx2, v.cy2, v.we, v.ns, v.swp, v.clr);
        end
        @(negedge clk);
        while (q.size() > 0) cmp(q.pop_front(), 63, "model");
        if (v.hd >= 0) begin
            h.d = v.hd; h.c1 = v.hc1; h.nb = v.hnb; h.c2 = v.hc2;
            h.busy = v.hbusy; h.sel = v.hsel; h.gen = v.hgen;
            cmp(h, v.hm, "vector");
        end
    endtask

    task automatic sweep();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 5; x++)
                step(mk(x, y, 4 - x, 2 - y, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    vec_t tbl [16];
    vec_t idle;
    exp_t e_rst;
    int busy_a, busy_c;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = hck(mk(1, 1, 0, 0, 1, 1, 0, 0), 0, M_C1 | M_SEL | M_GEN, 0, 8'h00, 0, 0, 0, 0);
        tbl[1]  = hck(mk(1, 1, 0, 0, 0, 0, 0, 0), 0, M_C1, 0, 8'h00, 0, 0, 0, 0);
        tbl[2]  = hck(mk(1, 1, 0, 0, 0, 0, 1, 0), 0, M_C1 | M_SEL | M_GEN, 0, 8'h00, 0, 0, 1, 1);
        tbl[3]  = hck(mk(1, 1, 0, 0, 0, 0, 0, 0), 0, M_C1 | M_SEL | M_GEN, 1, 8'h00, 0, 0, 1, 1);
        tbl[4]  = hck(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, M_C1 | M_NB, 0, 8'h80, 0, 0, 0, 0);
        tbl[5]  = mk(3, 2, 0, 0, 1, 1, 0, 0);
        tbl[5].cx1 = 4;
        tbl[6]  = hck(mk(0, 0, 0, 0, 0, 0, 1, 0), 0, M_SEL | M_GEN, 0, 8'h00, 0, 0, 0, 2);
        tbl[7]  = hck(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, M_NB, 0, 8'h00, 0, 0, 0, 0);
        tbl[8]  = hck(mk(0, 0, 0, 0, 0, 0, 0, 0), 1, M_NB, 0, 8'h01, 0, 0, 0, 0);
        tbl[9]  = hck(mk(0, 0, 0, 0, 0, 0, 0, 0), 2, M_NB, 0, 8'h01, 0, 0, 0, 0);
        tbl[10] = hck(mk(2, 0, 2, 0, 1, 1, 1, 0), 0, M_C2 | M_SEL | M_GEN, 0, 8'h00, 0, 0, 1, 3);
        tbl[11] = hck(mk(0, 0, 2, 0, 0, 0, 0, 0), 0, M_C2 | M_SEL | M_GEN, 0, 8'h00, 1, 0, 1, 3);
        tbl[12] = hck(mk(0, 0, 2, 0, 0, 0, 1, 0), 1, M_SEL | M_GEN, 0, 8'h00, 0, 0, 0, 0);
        tbl[13] = hck(mk(1, 3, 1, 3, 1, 1, 0, 0), 2, M_C1 | M_NB | M_C2, 0, 8'h00, 0, 0, 0, 0);
        tbl[13].cx1 = 5; tbl[13].cy1 = 0; tbl[13].cx2 = 5; tbl[13].cy2 = 0;
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 0);
        tbl[15] = hck(mk(1, 3, 1, 3, 0, 0, 0, 0), 0, M_C1 | M_NB | M_C2, 0, 8'h00, 0, 0, 0, 0);
        tbl[15].cx1 = 5; tbl[15].cy1 = 0; tbl[15].cx2 = 5; tbl[15].cy2 = 0;

        ax1 = '0; ay1 = '0; ax2 = '0; ay2 = '0; cx1 = '0; cy1 = '0; cx2 = '0; cy2 = '0;
        we = 0; ns = 0; swp = 0; clr = 0;
        for (int d = 0; d < 3; d++) begin
            mbusy[d] = 1'b1; mcnt[d] = 0; msel[d] = 0; mgen[d] = 0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            e_rst.d = d; e_rst.c1 = 0; e_rst.nb = '0; e_rst.c2 = 0;
            e_rst.busy = 1; e_rst.sel = 0; e_rst.gen = 0;
            cmp(e_rst, 63, "reset");
        end

        // Release reset and count the sweep length on both field sizes
        rst_n = 1'b1;
        busy_a = int'(ifa.o_busy);
        busy_c = int'(ifc.o_busy);
        repeat (18) begin
            step(idle);
            busy_a += int'(ifa.o_busy);
            busy_c += int'(ifc.o_busy);
        end
        cmp_int("reset_busy_4x3", busy_a, 12);
        cmp_int("reset_busy_5x3", busy_c, 15);
        sweep();

        for (int i = 0; i < 16; i++) step(tbl[i]);
        sweep();
        step(mk(0, 0, 0, 0, 0, 0, 1, 0));
        sweep();

        // Clear request colliding with a write and a swap
        step(hck(mk(0, 0, 0, 0, 1, 1, 1, 1), 0, M_BUSY | M_SEL | M_GEN, 0, 8'h00, 0, 1, 0, 0));
        busy_a = int'(ifa.o_busy);
        busy_c = int'(ifc.o_busy);
        repeat (17) begin
            step(idle);
            busy_a += int'(ifa.o_busy);
            busy_c += int'(ifc.o_busy);
        end
        cmp_int("clear_busy_4x3", busy_a, 12);
        cmp_int("clear_busy_5x3", busy_c, 15);
        step(hck(idle, 0, M_BUSY | M_SEL | M_GEN, 0, 8'h00, 0, 0, 0, 0));
        sweep();
        step(mk(0, 0, 0, 0, 0, 0, 1, 0));
        sweep();
        step(mk(0, 0, 0, 0, 0, 0, 1, 0));
        sweep();

        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = mk(int'($urandom_range(7)), int'($urandom_range(3)),
                   int'($urandom_range(7)), int'($urandom_range(3)),
                   $urandom_range(1) == 1, $urandom_range(1) == 1,
                   $urandom_range(9) == 0, $urandom_range(99) == 0);
            step(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
